// File: rtl/product_accumulator_isoschedule_pkg.sv
// Shared definitions for the isoschedule datapath.
//   INPUT_WIDTH/WEIGHT_WIDTH/ACC_WIDTH : operand and product widths
//   SUM_WIDTH/MAX_LEN                  : accumulator defaults
//   acc_state_e                        : accumulator FSM states
package isoschedule_pkg;
  localparam int INPUT_WIDTH  = 4;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ACC_WIDTH    = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_WIDTH    = 16;
  localparam int MAX_LEN      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;
endpackage

// File: rtl/product_accumulator_isoschedule_if.sv
// Product-in / sum-out handshake bundle for the accumulator.
//   prod_valid/prod_ready/prod : product stream from the multiplier
//   sum_valid/sum_ready/sum    : finished dot product toward writeback
//   master : the side feeding products and taking sums
//   slave  : the accumulator
interface product_accumulator_isoschedule_if
  import isoschedule_pkg::*;
#(
  parameter int ACC_WIDTH = isoschedule_pkg::ACC_WIDTH,
  parameter int SUM_WIDTH = isoschedule_pkg::SUM_WIDTH
);
  logic                 prod_valid;
  logic                 prod_ready;
  logic [ACC_WIDTH-1:0] prod;
  logic                 sum_valid;
  logic                 sum_ready;
  logic [SUM_WIDTH-1:0] sum;

  modport master (output prod_valid, prod, sum_ready,
                  input  prod_ready, sum_valid, sum);
  modport slave  (input  prod_valid, prod, sum_ready,
                  output prod_ready, sum_valid, sum);
endinterface

// File: rtl/product_accumulator_isoschedule_adder_sat.sv
// acc_adder_sat: combinational acc + zero-extended product.
// Optional build macro ACC_SATURATE_EN clamps overflow to all-ones;
// without it the add wraps modulo 2^SUM_WIDTH.
//   a : running sum   b : unsigned product   y : next sum
module acc_adder_sat #(
  parameter int ACC_WIDTH = 12,
  parameter int SUM_WIDTH = 16
) (
  input  logic [SUM_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0] y
);
`ifdef ACC_SATURATE_EN
  // One extra bit catches the carry out; once clamped, any further
  // non-negative add carries again, so saturation is sticky for free.
  logic [SUM_WIDTH:0] full;
  assign full = {1'b0, a} + (SUM_WIDTH+1)'(b);
  assign y    = full[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : full[SUM_WIDTH-1:0];
`else
  assign y = a + SUM_WIDTH'(b);
`endif
endmodule

// File: rtl/product_accumulator_isoschedule.sv
// product_accumulator_isoschedule: sums a run-time number of products
// (one dot product) from the multiplier and presents the result on a
// valid/ready port.
//   clk, rst   : clock, synchronous active-high reset
//   start, len : begin a dot product of len products (sampled in IDLE,
//                len clamped to MAX_LEN)
//   busy       : FSM not idle
//   bus        : slave side of the product/sum handshake interface
// Optional build macro ACC_SATURATE_EN (see acc_adder_sat).
module product_accumulator_isoschedule
  import isoschedule_pkg::*;
#(
  parameter int ACC_WIDTH = isoschedule_pkg::ACC_WIDTH,
  parameter int SUM_WIDTH = isoschedule_pkg::SUM_WIDTH,
  parameter int MAX_LEN   = isoschedule_pkg::MAX_LEN,
  parameter int LEN_WIDTH = $clog2(MAX_LEN+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  product_accumulator_isoschedule_if.slave bus
);
  acc_state_e           state, state_nx;
  logic [SUM_WIDTH-1:0] acc, acc_add;
  logic [LEN_WIDTH-1:0] cnt, len_q, len_c;
  logic                 take, load, last;

  assign len_c = (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
  assign last  = (cnt == len_q - LEN_WIDTH'(1));

  acc_adder_sat #(.ACC_WIDTH(ACC_WIDTH), .SUM_WIDTH(SUM_WIDTH)) u_add (
    .a(acc), .b(bus.prod), .y(acc_add)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Handshake outputs decode the registered state only, so prod_ready
  // has no combinational path from prod_valid.
  always_comb begin
    state_nx       = state;
    load           = 1'b0;
    take           = 1'b0;
    bus.prod_ready = 1'b0;
    bus.sum_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (len_c == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        bus.prod_ready = 1'b1;
        take           = bus.prod_valid;
        if (take && last) state_nx = DONE;
      end
      DONE: begin
        bus.sum_valid = 1'b1;
        if (bus.sum_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= len_c;
    end else if (take) begin
      acc   <= acc_add;
      cnt   <= cnt + LEN_WIDTH'(1);
    end
  end

  assign bus.sum = acc;
  assign busy    = (state != IDLE);
endmodule
